// File: rtl/gate_sim_pkg.sv
// Shared definitions for the gate-level array models: delay-mode codes and
// the inertial counter width helper.
package gate_sim_pkg;

    localparam int MODE_TRANSPORT = 0;
    localparam int MODE_INERTIAL  = 1;

    // Counter must hold 0..DELAY-1; a 1-bit counter is kept even when DELAY <= 2.
    function automatic int cnt_width(input int delay);
        return (delay <= 2) ? 1 : $clog2(delay);
    endfunction

endpackage

// File: rtl/nor_channel.sv
// One NOR gate: fan-in reduction, transport delay line or inertial filter,
// and supply/reset handling.
module nor_channel
    import gate_sim_pkg::*;
#(
    parameter int   FANIN = 2,
    parameter int   DELAY = 9,
    parameter logic IC    = 1'b0,
    parameter int   MODE  = MODE_TRANSPORT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_ok,
    input  logic [FANIN-1:0] a,
    output logic             y
);

    logic n;
    logic y_q;
    logic reload;

    assign n      = ~|a;
    assign reload = rst | ~pwr_ok;

    generate
        if (MODE == MODE_TRANSPORT) begin : g_transport
            logic [DELAY-1:0] stage;

            // NOTE: the whole delay line is reset, not just the output stage;
            // otherwise stale pre-reset samples would surface on y afterwards.
            always_ff @(posedge clk) begin
                if (reload) begin
                    stage <= {DELAY{IC}};
                end else begin
                    // NOTE: non-blocking assignments let every stage take its
                    // neighbour's old value, so loop order does not matter.
                    stage[0] <= n;
                    for (int i = 1; i < DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign y_q = stage[DELAY-1];
        end else begin : g_inertial
            localparam int CW = cnt_width(DELAY);

            logic [CW-1:0] cnt;
            logic          y_r;

            always_ff @(posedge clk) begin
                if (reload) begin
                    y_r <= IC;
                    cnt <= '0;
                end else if (n == y_r) begin
                    cnt <= '0;
                end else if (cnt == CW'(DELAY - 1)) begin
                    y_r <= n;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign y_q = y_r;
        end
    endgenerate

    // Supply fault forces the output low without waiting for a clock.
    assign y = pwr_ok & y_q;

endmodule

// File: rtl/nor_array.sv
// Parametrised bank of independent NOR gates with configurable fan-in,
// delay, initial condition and delay mode.
module nor_array
    import gate_sim_pkg::*;
#(
    parameter int                CHANNELS = 4,
    parameter int                FANIN    = 2,
    parameter int                DELAY    = 9,
    parameter logic [CHANNELS-1:0] IC     = '0,
    parameter int                MODE     = MODE_TRANSPORT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vcc,
    input  logic                      gnd,
    input  logic [CHANNELS*FANIN-1:0] a,
    output logic [CHANNELS-1:0]       y
);

    generate
        if (CHANNELS < 1 || FANIN < 1 || DELAY < 1) begin : g_bad_size
            $error("nor_array: CHANNELS, FANIN and DELAY must all be >= 1");
        end
        if (MODE != MODE_TRANSPORT && MODE != MODE_INERTIAL) begin : g_bad_mode
            $error("nor_array: MODE must be 0 (transport) or 1 (inertial)");
        end
    endgenerate

    logic pwr_ok;

    assign pwr_ok = vcc & ~gnd;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            nor_channel #(
                .FANIN (FANIN),
                .DELAY (DELAY),
                .IC    (IC[i]),
                .MODE  (MODE)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .pwr_ok (pwr_ok),
                .a      (a[i*FANIN +: FANIN]),
                .y      (y[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_nor_array.sv
// Self-checking bench: four nor_array configurations driven together and
// compared every cycle against a sample-history model, plus literal checks.
module tb_nor_array;

    localparam int NI   = 4;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vcc = 1'b1;
    logic       gnd = 1'b0;
    logic [7:0] a8  = '0;
    logic [3:0] a4  = '0;
    logic [3:0] y0, y1;
    logic       y2, y3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nor_array #(.CHANNELS(4), .FANIN(2), .DELAY(3), .IC(4'b1010), .MODE(0)) u_tp (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a8), .y(y0));
    nor_array #(.CHANNELS(4), .FANIN(2), .DELAY(3), .IC(4'b1010), .MODE(1)) u_in (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a8), .y(y1));
    nor_array #(.CHANNELS(1), .FANIN(4), .DELAY(1), .IC(1'b1), .MODE(0)) u_w_tp (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a4), .y(y2));
    nor_array #(.CHANNELS(1), .FANIN(4), .DELAY(1), .IC(1'b1), .MODE(1)) u_w_in (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a4), .y(y3));

    function automatic int ch_of(input int i);    return (i < 2) ? 4 : 1; endfunction
    function automatic int fan_of(input int i);   return (i < 2) ? 2 : 4; endfunction
    function automatic int dly_of(input int i);   return (i < 2) ? 3 : 1; endfunction
    function automatic int mode_of(input int i);  return i % 2;           endfunction
    function automatic logic [3:0] ic_of(input int i);
        return (i < 2) ? 4'b1010 : 4'b0001;
    endfunction

    // Reference: per-edge NOR samples, edge of last reload, inertial output state.
    logic [3:0] smp [NI][MAXE];
    int         last_r [NI];
    int         upd [NI][4];
    logic [3:0] yin [NI];
    int         ec      = 0;
    bit         started = 1'b0;

    function automatic logic [3:0] nor_vec(input int i);
        logic [3:0] nv;
        logic [7:0] av;
        nv = '0;
        av = (i < 2) ? a8 : {4'b0, a4};
        for (int c = 0; c < ch_of(i); c++) begin
            nv[c] = 1'b1;
            for (int j = 0; j < fan_of(i); j++)
                if (av[c*fan_of(i) + j]) nv[c] = 1'b0;
        end
        return nv;
    endfunction

    always @(posedge clk) begin
        bit         pwr;
        logic [3:0] nv;
        logic [3:0] icv;
        pwr = vcc & ~gnd;
        ec  = ec + 1;
        if (ec >= MAXE) begin
            $display("FAIL edge_budget: got %0d edges, limit %0d", ec, MAXE);
            $fatal(1, "edge budget exceeded");
        end
        for (int i = 0; i < NI; i++) begin
            nv = nor_vec(i);
            smp[i][ec] = nv;
            if (rst || !pwr) begin
                started   = 1'b1;
                last_r[i] = ec;
                icv       = ic_of(i);
                yin[i]    = icv;
                for (int c = 0; c < 4; c++) upd[i][c] = ec;
            end else if (mode_of(i) == 1) begin
                // Output flips once the last DELAY samples since the previous
                // change all disagree with it.
                for (int c = 0; c < ch_of(i); c++) begin
                    if (ec - upd[i][c] >= dly_of(i)) begin
                        bit all_diff;
                        all_diff = 1'b1;
                        for (int k = ec - dly_of(i) + 1; k <= ec; k++)
                            if (smp[i][k][c] == yin[i][c]) all_diff = 1'b0;
                        if (all_diff) begin
                            yin[i][c] = ~yin[i][c];
                            upd[i][c] = ec;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [3:0] expect_y(input int i);
        logic [3:0] r;
        logic [3:0] icv;
        logic [3:0] s;
        r = '0;
        if (!(vcc & ~gnd)) return '0;
        if (mode_of(i) == 1) return yin[i];
        icv = ic_of(i);
        for (int c = 0; c < ch_of(i); c++) begin
            if (ec - last_r[i] >= dly_of(i)) begin
                s    = smp[i][ec - dly_of(i) + 1];
                r[c] = s[c];
            end else begin
                r[c] = icv[c];
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] get_y(input int i);
        case (i)
            0:       return y0;
            1:       return y1;
            2:       return {3'b000, y2};
            default: return {3'b000, y3};
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started)
            for (int i = 0; i < NI; i++)
                check($sformatf("model_inst%0d", i), get_y(i), expect_y(i));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and converge
        step(); step();
        check("rst_tp", y0, 4'b1010);
        check("rst_in", y1, 4'b1010);
        check("rst_w",  {3'b0, y2}, 4'b0001);
        rst = 1'b0;
        step(); check("conv_e1", y0, 4'b1010);
        step(); check("conv_e2", y0, 4'b1010);
        step(); check("conv_e3_tp", y0, 4'b1111);
        check("conv_e3_in", y1, 4'b1111);

        // Transport 1-cycle pulse on channel 0
        a8 = 8'h01;
        step(); a8 = 8'h00;
        check("tp_pulse_s0", y0, 4'b1111);
        step(); check("tp_pulse_s1", y0, 4'b1111);
        step(); check("tp_pulse_s2", y0, 4'b1110);
        check("in_rej1", y1, 4'b1111);
        step(); check("tp_pulse_s3", y0, 4'b1111);

        // Inertial: 2-cycle pulse rejected
        a8 = 8'h01;
        step(); step(); a8 = 8'h00;
        repeat (4) begin
            step(); check("in_rej2", y1, 4'b1111);
        end

        // Inertial: 3-cycle pulse passes
        a8 = 8'h01;
        step(); step(); check("in_pass_s1", y1, 4'b1111);
        step(); check("in_pass_s2", y1, 4'b1110);
        a8 = 8'h00;
        step(); check("in_ret_s3", y1, 4'b1110);
        step(); check("in_ret_s4", y1, 4'b1110);
        step(); check("in_ret_s5", y1, 4'b1111);

        // Power fault via vcc
        vcc = 1'b0; #1;
        check("vcc_off_tp", y0, 4'b0000);
        check("vcc_off_in", y1, 4'b0000);
        check("vcc_off_w",  {3'b0, y2}, 4'b0000);
        step(); check("vcc_off_hold", y0, 4'b0000);
        vcc = 1'b1; #1;
        check("vcc_on_tp", y0, 4'b1010);
        check("vcc_on_in", y1, 4'b1010);
        step(); step(); check("vcc_on_e2", y0, 4'b1010);
        step(); check("vcc_on_e3", y0, 4'b1111);

        // Power fault via gnd
        gnd = 1'b1; #1;
        check("gnd_off", y0, 4'b0000);
        step(); gnd = 1'b0; #1;
        check("gnd_on", y0, 4'b1010);
        step(); step(); step(); check("gnd_on_e3", y0, 4'b1111);

        // Reset while an inertial count is pending
        a8 = 8'h01;
        step(); step();
        rst = 1'b1;
        step(); check("rst_mid_in", y1, 4'b1010);
        rst = 1'b0;
        step(); check("rst_mid_e1", y1, 4'b1010);
        step(); check("rst_mid_e2", y1, 4'b1010);
        step(); check("rst_mid_e3", y1, 4'b1110);
        a8 = 8'h00;
        step(); check("rst_mid_e4", y1, 4'b1110);
        step(); check("rst_mid_e5", y1, 4'b1110);
        step(); check("rst_mid_e6", y1, 4'b1111);

        // Width sweep, DELAY=1, both modes
        for (int v = 0; v < 16; v++) begin
            a4 = 4'(v);
            step();
            check($sformatf("sweep_tp_%0d", v), {3'b0, y2}, {3'b0, (v == 0)});
            check($sformatf("sweep_in_%0d", v), {3'b0, y3}, {3'b0, (v == 0)});
        end

        // Randomized run with occasional reset and supply faults
        repeat (1500) begin
            int r;
            step();
            r   = $urandom_range(0, 99);
            rst = (r < 2);
            vcc = !(r >= 2 && r < 4);
            gnd = (r >= 4 && r < 6);
            if ($urandom_range(0, 3) == 0) a8 = 8'($urandom);
            a4 = 4'($urandom);
        end
        rst = 1'b0; vcc = 1'b1; gnd = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
